// File: rtl/life_gen_scheduler.sv
`timescale 1ns/1ps
// life_gen_scheduler
// Sequences Game-of-Life generations over two ping-pong cell banks. The
// life engine reads display_bank and writes the other bank; the displayed
// bank only flips on a frame boundary, so the pixel path never sees a
// half-written grid. Cursor draw writes are arbitrated against the engine.
module life_gen_scheduler #(
  parameter int FRAMES_PER_GEN = 30,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int GEN_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             run_en,
  input  logic             step_req,
  input  logic             gen_done,
  input  logic             draw_req,
  output logic             engine_start,
  output logic             display_bank,
  output logic             draw_grant,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    COMPUTE   = 2'd2,
    SWAP_WAIT = 2'd3
  } state_t;

  localparam logic [7:0]  FRAME_LAST = 8'(FRAMES_PER_GEN - 1);
  localparam int          WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] WD_LIMIT   = 32'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [7:0]        frame_cnt_reg;
  logic              step_pending_reg;
  logic              launch_defer_reg, launch_defer_next;
  logic              grant_prev_reg;
  logic [WD_W-1:0]   wdog_reg;
  logic              display_bank_reg;
  logic [GEN_W-1:0]  gen_count_reg;
  logic              timeout_err_reg;

  logic              gen_due;
  logic              wd_hit;
  logic              do_swap;
  logic              do_timeout;

  // gen_due is only meaningful together with frame_start; a due generation
  // that lands while the engine is still busy is simply skipped.
  assign gen_due = frame_start && run_en && (frame_cnt_reg == FRAME_LAST);

  // Watchdog fires when the cycle count since engine_start reaches the limit.
  assign wd_hit = ((32'(wdog_reg) + 32'd1) >= WD_LIMIT);

  assign display_bank = display_bank_reg;
  assign gen_count    = gen_count_reg;
  assign timeout_err  = timeout_err_reg;

  // Frame divider: counts frames in run mode, held at zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_reg <= '0;
    end else if (!run_en) begin
      frame_cnt_reg <= '0;
    end else if (frame_start) begin
      frame_cnt_reg <= gen_due ? 8'd0 : frame_cnt_reg + 8'd1;
    end
  end

  // Single-deep step request latch; a new request wins over the launch clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_pending_reg <= 1'b0;
    end else if (step_req) begin
      step_pending_reg <= 1'b1;
    end else if (state_reg == START) begin
      step_pending_reg <= 1'b0;
    end
  end

  // Engine watchdog: cleared at launch, counts while computing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_reg <= '0;
    end else if (state_reg == START) begin
      wdog_reg <= '0;
    end else if (state_reg == COMPUTE) begin
      wdog_reg <= wdog_reg + WD_W'(1);
    end
  end

  // FSM state plus launch-deferral and grant-spacing history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      launch_defer_reg <= 1'b0;
      grant_prev_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      launch_defer_reg <= launch_defer_next;
      grant_prev_reg   <= draw_grant;
    end
  end

  // Next-state and control outputs; a draw in the launch cycle is served
  // first and the launch slips by one cycle.
  always_comb begin
    state_next        = state_reg;
    launch_defer_next = launch_defer_reg;
    engine_start      = 1'b0;
    busy              = 1'b0;
    draw_grant        = 1'b0;
    do_swap           = 1'b0;
    do_timeout        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (launch_defer_reg) begin
          state_next        = START;
          launch_defer_next = 1'b0;
        end else begin
          draw_grant = draw_req && !grant_prev_reg && !reset;
          if (frame_start && (gen_due || step_pending_reg)) begin
            if (draw_grant) begin
              launch_defer_next = 1'b1;
            end else begin
              state_next = START;
            end
          end
        end
      end
      START: begin
        engine_start = 1'b1;
        busy         = 1'b1;
        state_next   = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (gen_done) begin
          state_next = SWAP_WAIT;
        end else if (wd_hit) begin
          do_timeout = 1'b1;
          state_next = IDLE;
        end
      end
      SWAP_WAIT: begin
        busy = 1'b1;
        if (frame_start) begin
          do_swap    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bank flip and generation count on a completed swap; sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_bank_reg <= 1'b0;
      gen_count_reg    <= '0;
      timeout_err_reg  <= 1'b0;
    end else begin
      if (do_swap) begin
        display_bank_reg <= ~display_bank_reg;
        gen_count_reg    <= gen_count_reg + GEN_W'(1);
      end
      if (do_timeout) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

endmodule
